alu_seq_div: RTL

Iterative unsigned divider controller for the `WORD_WIDTH`-bit integer datapath. It sequences a single shared add/subtract stage: one restoring shift-subtract step per cycle, with a start/busy/done handshake. It sits beside the ALU in the execute stage and serves multi-cycle DIV/REM operations that the single-cycle ALU cannot. The quotient and remainder are held stable until the next accepted start.

---
 rtl/alu_seq_div_if.sv | 25 ++
 rtl/alu_seq_div.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_seq_div_if.sv
// Handshake and operand/result bundle for the iterative unsigned divider.
// The requester drives start and operands; the divider returns status and results.
interface alu_seq_div_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  start;
  logic [WORD_WIDTH-1:0] dividend;
  logic [WORD_WIDTH-1:0] divisor;
  logic                  busy;
  logic                  done;
  logic [WORD_WIDTH-1:0] quotient;
  logic [WORD_WIDTH-1:0] remainder;
  logic                  dbz;
  logic                  z;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz, z
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz, z
  );
endinterface

// File: rtl/alu_seq_div.sv
// Iterative restoring unsigned divider: one shift-subtract step per cycle through a
// single subtractor, start/busy/done handshake, results held until the next division.
module alu_seq_div #(
  parameter int WORD_WIDTH = 32
) (
  input  logic          clk,
  input  logic          nrst,
  alu_seq_div_if.slave  bus
);

  localparam int CW = $clog2(WORD_WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] dvd_q, dvd_d;   // dividend bits out at the top, quotient bits in at the bottom
  logic [WORD_WIDTH-1:0] dvs_q, dvs_d;
  logic [WORD_WIDTH-1:0] rem_q, rem_d;
  logic                  zpend_q, zpend_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [WORD_WIDTH-1:0] quo_q, quo_d;
  logic [WORD_WIDTH-1:0] rmd_q, rmd_d;
  logic                  dbz_q, dbz_d;

  logic [WORD_WIDTH:0]   r_shift;
  logic [WORD_WIDTH:0]   diff;
  logic                  q_bit;
  logic [WORD_WIDTH-1:0] step_rem;
  logic [WORD_WIDTH-1:0] step_quo;

  // The stored partial remainder never exceeds the divisor, so its top bit is
  // always zero and only the shifted value needs the extra bit.
  always_comb begin
    r_shift  = {rem_q, dvd_q[WORD_WIDTH-1]};
    diff     = r_shift - {1'b0, dvs_q};
    q_bit    = ~diff[WORD_WIDTH];
    step_rem = q_bit ? diff[WORD_WIDTH-1:0] : r_shift[WORD_WIDTH-1:0];
    step_quo = {dvd_q[WORD_WIDTH-2:0], q_bit};
  end

  // NOTE: every signal gets a hold/default value first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    zpend_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;

    // A divide-by-zero accepted last edge publishes its result one edge later.
    if (zpend_q) begin
      quo_d  = '1;
      rmd_d  = dvd_q;
      dbz_d  = 1'b1;
      done_d = 1'b1;
    end

    case (state_q)
      ST_CALC: begin
        cnt_d = cnt_q - CW'(1);
        dvd_d = step_quo;
        rem_d = step_rem;
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quo_d   = step_quo;
          rmd_d   = step_rem;
        end
      end
      default: begin
        if (bus.start) begin
          if (bus.divisor != '0) begin
            state_d = ST_CALC;
            busy_d  = 1'b1;
            cnt_d   = CW'(WORD_WIDTH);
            dvd_d   = bus.dividend;
            dvs_d   = bus.divisor;
            rem_d   = '0;
            if (!zpend_q) dbz_d = 1'b0;
          end else begin
            state_d = ST_DONE;
            zpend_d = 1'b1;
            dvd_d   = bus.dividend;
            dvs_d   = '0;
          end
        end
      end
    endcase
  end

  // NOTE: reset is synchronous and clears every register, datapath included.
  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      zpend_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      zpend_q <= zpend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rmd_q;
  assign bus.dbz       = dbz_q;
  assign bus.z         = (quo_q == '0);

endmodule
